// File: rtl/mesi_isc_broad_cntl_n.sv
// Broadcast controller for an N-CPU MESI intersection controller: snoops every
// enabled non-originating CPU, then grants the originator and pops the FIFO.
module mesi_isc_broad_cntl_n #(
  parameter int CPU_NUM          = 4,
  parameter int CPU_ID_WIDTH     = 2,
  parameter int CBUS_CMD_WIDTH   = 3,
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 5,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CPU_NUM-1:0]                  cbus_ack_array_i,
  input  logic [CPU_NUM-1:0]                  cpu_en_mask_i,
  input  logic                                fifo_status_empty_i,
  input  logic [BROAD_TYPE_WIDTH-1:0]         broad_snoop_type_i,
  input  logic [CPU_ID_WIDTH-1:0]             broad_snoop_cpu_id_i,
  input  logic [BROAD_ID_WIDTH-1:0]           broad_snoop_id_i,
  input  logic                                err_clr_i,
  output logic [CPU_NUM*CBUS_CMD_WIDTH-1:0]   cbus_cmd_array_o,
  output logic                                broad_fifo_rd_o,
  output logic                                busy_o,
  output logic                                timeout_err_o,
  output logic [BROAD_ID_WIDTH-1:0]           err_id_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CPU_ID_WIDTH:0] CPU_NUM_L = (CPU_ID_WIDTH + 1)'(CPU_NUM);

  localparam logic [BROAD_TYPE_WIDTH-1:0] T_NOP = BROAD_TYPE_WIDTH'(0);
  localparam logic [BROAD_TYPE_WIDTH-1:0] T_WR  = BROAD_TYPE_WIDTH'(1);
  localparam logic [BROAD_TYPE_WIDTH-1:0] T_RD  = BROAD_TYPE_WIDTH'(2);

  localparam logic [CBUS_CMD_WIDTH-1:0] C_NOP      = CBUS_CMD_WIDTH'(0);
  localparam logic [CBUS_CMD_WIDTH-1:0] C_WR_SNOOP = CBUS_CMD_WIDTH'(1);
  localparam logic [CBUS_CMD_WIDTH-1:0] C_RD_SNOOP = CBUS_CMD_WIDTH'(2);
  localparam logic [CBUS_CMD_WIDTH-1:0] C_EN_WR    = CBUS_CMD_WIDTH'(3);
  localparam logic [CBUS_CMD_WIDTH-1:0] C_EN_RD    = CBUS_CMD_WIDTH'(4);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SNOOP  = 2'd1,
    S_ENABLE = 2'd2,
    S_POP    = 2'd3
  } state_t;

  state_t                           state_q, state_d;
  logic [CPU_NUM-1:0]               pending_q, pending_d;
  logic [TW-1:0]                    timer_q, timer_d;
  logic [BROAD_TYPE_WIDTH-1:0]      type_q, type_d;
  logic [CPU_ID_WIDTH-1:0]          src_q, src_d;
  logic [BROAD_ID_WIDTH-1:0]        id_q, id_d;
  logic [CPU_NUM*CBUS_CMD_WIDTH-1:0] cmd_d;
  logic                             rd_d, busy_d;
  logic                             err_d;
  logic [BROAD_ID_WIDTH-1:0]        err_id_d;
  logic                             set_err;
  logic [BROAD_ID_WIDTH-1:0]        err_src_id;
  logic [CPU_NUM-1:0]               src_onehot;
  logic                             src_ok;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    timer_d    = timer_q;
    type_d     = type_q;
    src_d      = src_q;
    id_d       = id_q;
    set_err    = 1'b0;
    err_src_id = id_q;
    err_d      = timeout_err_o;
    err_id_d   = err_id_o;
    cmd_d      = '0;
    src_onehot = CPU_NUM'(1) << broad_snoop_cpu_id_i;
    src_ok     = {1'b0, broad_snoop_cpu_id_i} < CPU_NUM_L;

    case (state_q)
      S_IDLE: begin
        if (!fifo_status_empty_i) begin
          type_d = broad_snoop_type_i;
          src_d  = broad_snoop_cpu_id_i;
          id_d   = broad_snoop_id_i;
          if ((broad_snoop_type_i == T_WR || broad_snoop_type_i == T_RD) && src_ok) begin
            pending_d = cpu_en_mask_i & ~src_onehot;
            timer_d   = '0;
            state_d   = (|pending_d) ? S_SNOOP : S_ENABLE;
          end else if (broad_snoop_type_i == T_NOP) begin
            state_d = S_POP;
          end else begin
            set_err    = 1'b1;
            err_src_id = broad_snoop_id_i;
            state_d    = S_POP;
          end
        end
      end
      S_SNOOP: begin
        pending_d = pending_q & ~cbus_ack_array_i;
        if (pending_d == '0) begin
          timer_d = '0;
          state_d = S_ENABLE;
        end else if (timer_q == TIMER_MAX) begin
          pending_d = '0;
          set_err   = 1'b1;
          state_d   = S_POP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_ENABLE: begin
        if (cbus_ack_array_i[src_q]) begin
          state_d = S_POP;
        end else if (timer_q == TIMER_MAX) begin
          set_err = 1'b1;
          state_d = S_POP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new error always beats a clear issued in the same cycle.
    if (set_err) begin
      err_d = 1'b1;
      if (!timeout_err_o) err_id_d = err_src_id;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end

    // Commands are derived from the next state so they appear registered.
    for (int i = 0; i < CPU_NUM; i++) begin
      if (state_d == S_SNOOP && pending_d[i])
        cmd_d[i*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = (type_d == T_WR) ? C_WR_SNOOP : C_RD_SNOOP;
      else if (state_d == S_ENABLE && src_d == CPU_ID_WIDTH'(i))
        cmd_d[i*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = (type_d == T_WR) ? C_EN_WR : C_EN_RD;
      else
        cmd_d[i*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = C_NOP;
    end
    rd_d   = (state_d == S_POP);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      pending_q        <= '0;
      timer_q          <= '0;
      type_q           <= '0;
      src_q            <= '0;
      id_q             <= '0;
      cbus_cmd_array_o <= '0;
      broad_fifo_rd_o  <= 1'b0;
      busy_o           <= 1'b0;
      timeout_err_o    <= 1'b0;
      err_id_o         <= '0;
    end else begin
      state_q          <= state_d;
      pending_q        <= pending_d;
      timer_q          <= timer_d;
      type_q           <= type_d;
      src_q            <= src_d;
      id_q             <= id_d;
      cbus_cmd_array_o <= cmd_d;
      broad_fifo_rd_o  <= rd_d;
      busy_o           <= busy_d;
      timeout_err_o    <= err_d;
      err_id_o         <= err_id_d;
    end
  end

endmodule

// File: tb/tb_mesi_isc_broad_cntl_n.sv
// Directed bench for the N-CPU broadcast controller: a 4-CPU instance with a
// short timeout and an 8-CPU instance, driven and checked on the falling edge.
module tb_mesi_isc_broad_cntl_n;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  // 4-CPU instance
  logic [3:0]  a_ack, a_mask;
  logic        a_empty, a_clr;
  logic [1:0]  a_type, a_src;
  logic [4:0]  a_id;
  logic [11:0] a_cmd;
  logic        a_rd, a_busy, a_err;
  logic [4:0]  a_err_id;

  // 8-CPU instance
  logic [7:0]  b_ack, b_mask;
  logic        b_empty, b_clr;
  logic [1:0]  b_type;
  logic [2:0]  b_src;
  logic [4:0]  b_id;
  logic [23:0] b_cmd;
  logic        b_rd, b_busy, b_err;
  logic [4:0]  b_err_id;

  mesi_isc_broad_cntl_n #(.CPU_NUM(4), .CPU_ID_WIDTH(2), .TIMEOUT_CYCLES(8)) dut_a (
    .clk(clk), .rst(rst),
    .cbus_ack_array_i(a_ack), .cpu_en_mask_i(a_mask),
    .fifo_status_empty_i(a_empty), .broad_snoop_type_i(a_type),
    .broad_snoop_cpu_id_i(a_src), .broad_snoop_id_i(a_id), .err_clr_i(a_clr),
    .cbus_cmd_array_o(a_cmd), .broad_fifo_rd_o(a_rd), .busy_o(a_busy),
    .timeout_err_o(a_err), .err_id_o(a_err_id)
  );

  mesi_isc_broad_cntl_n #(.CPU_NUM(8), .CPU_ID_WIDTH(3)) dut_b (
    .clk(clk), .rst(rst),
    .cbus_ack_array_i(b_ack), .cpu_en_mask_i(b_mask),
    .fifo_status_empty_i(b_empty), .broad_snoop_type_i(b_type),
    .broad_snoop_cpu_id_i(b_src), .broad_snoop_id_i(b_id), .err_clr_i(b_clr),
    .cbus_cmd_array_o(b_cmd), .broad_fifo_rd_o(b_rd), .busy_o(b_busy),
    .timeout_err_o(b_err), .err_id_o(b_err_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_a(input string tag, input logic [11:0] cmd, input logic rd, input logic busy);
    check({tag, ".cmd"}, 32'(a_cmd), 32'(cmd));
    check({tag, ".rd"}, 32'(a_rd), 32'(rd));
    check({tag, ".busy"}, 32'(a_busy), 32'(busy));
  endtask

  task automatic expect_err_a(input string tag, input logic err, input logic [4:0] id);
    check({tag, ".err"}, 32'(a_err), 32'(err));
    check({tag, ".err_id"}, 32'(a_err_id), 32'(id));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    a_ack = '0; a_mask = '0; a_empty = 1'b1; a_clr = 1'b0;
    a_type = '0; a_src = '0; a_id = '0;
    b_ack = '0; b_mask = '0; b_empty = 1'b1; b_clr = 1'b0;
    b_type = '0; b_src = '0; b_id = '0;
    step();
    step();
    expect_a("reset", 12'h000, 1'b0, 1'b0);
    expect_err_a("reset", 1'b0, 5'd0);
    check("reset.b_cmd", 32'(b_cmd), 32'h0);
    rst = 1'b1;
    step();

    // WR src=1, all enabled: snoop CPUs 0,2,3 then enable CPU1
    a_mask = 4'hF; a_type = 2'd1; a_src = 2'd1; a_id = 5'd5; a_empty = 1'b0;
    step(); expect_a("wr.snoop", 12'h241, 1'b0, 1'b1);
    a_ack = 4'b0001;
    step(); expect_a("wr.ack0", 12'h240, 1'b0, 1'b1);
    a_ack = 4'b0100;
    step(); expect_a("wr.ack2", 12'h200, 1'b0, 1'b1);
    a_ack = 4'b1000;
    step(); expect_a("wr.enable", 12'h018, 1'b0, 1'b1);
    a_ack = 4'b0000;
    step(); expect_a("wr.enable_hold", 12'h018, 1'b0, 1'b1);
    a_ack = 4'b0010;
    step(); expect_a("wr.pop", 12'h000, 1'b1, 1'b1);
    a_ack = 4'b0000; a_empty = 1'b1;
    step(); expect_a("wr.idle", 12'h000, 1'b0, 1'b0);
    step(); expect_a("wr.idle2", 12'h000, 1'b0, 1'b0);

    // RD src=0 with only itself enabled: straight to ENABLE
    a_mask = 4'b0001; a_type = 2'd2; a_src = 2'd0; a_id = 5'd3; a_empty = 1'b0;
    step(); expect_a("rd_skip.enable", 12'h004, 1'b0, 1'b1);
    a_ack = 4'b0001;
    step(); expect_a("rd_skip.pop", 12'h000, 1'b1, 1'b1);
    a_ack = 4'b0000; a_empty = 1'b1;
    step(); expect_a("rd_skip.idle", 12'h000, 1'b0, 1'b0);
    expect_err_a("rd_skip", 1'b0, 5'd0);

    // RD src=2, CPU3 never acks: timeout after 8 SNOOP cycles
    a_mask = 4'hF; a_type = 2'd2; a_src = 2'd2; a_id = 5'd13; a_empty = 1'b0;
    step(); expect_a("to.snoop", 12'h412, 1'b0, 1'b1);
    a_ack = 4'b0011;
    step(); expect_a("to.ack01", 12'h400, 1'b0, 1'b1);
    a_ack = 4'b0000; a_mask = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      step(); expect_a($sformatf("to.wait%0d", i), 12'h400, 1'b0, 1'b1);
      expect_err_a("to.wait", 1'b0, 5'd0);
    end
    step(); expect_a("to.pop", 12'h000, 1'b1, 1'b1);
    expect_err_a("to.pop", 1'b1, 5'd13);
    a_empty = 1'b1;
    step(); expect_a("to.idle", 12'h000, 1'b0, 1'b0);
    expect_err_a("to.idle", 1'b1, 5'd13);
    a_clr = 1'b1;
    step(); expect_err_a("to.clr", 1'b0, 5'd13);
    a_clr = 1'b0;

    // ENABLE ack arriving on the timeout cycle completes without error
    a_mask = 4'b0001; a_type = 2'd2; a_src = 2'd0; a_id = 5'd7; a_empty = 1'b0;
    step(); expect_a("late.enable", 12'h004, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(); expect_a($sformatf("late.wait%0d", i), 12'h004, 1'b0, 1'b1);
    end
    a_ack = 4'b0001;
    step(); expect_a("late.pop", 12'h000, 1'b1, 1'b1);
    expect_err_a("late.pop", 1'b0, 5'd13);
    a_ack = 4'b0000; a_empty = 1'b1;
    step();

    // Illegal type: error and pop, no commands
    a_type = 2'd3; a_src = 2'd0; a_id = 5'd9; a_mask = 4'hF; a_empty = 1'b0;
    step(); expect_a("ill.pop", 12'h000, 1'b1, 1'b1);
    expect_err_a("ill.pop", 1'b1, 5'd9);
    a_empty = 1'b1;
    step(); expect_a("ill.idle", 12'h000, 1'b0, 1'b0);
    a_clr = 1'b1;
    step(); a_clr = 1'b0;
    expect_err_a("ill.clr", 1'b0, 5'd9);

    // NOP type: silent drop
    a_type = 2'd0; a_id = 5'd4; a_empty = 1'b0;
    step(); expect_a("nop.pop", 12'h000, 1'b1, 1'b1);
    expect_err_a("nop.pop", 1'b0, 5'd9);
    a_empty = 1'b1;
    step(); expect_a("nop.idle", 12'h000, 1'b0, 1'b0);

    // 8 CPUs: WR src=7, all other CPUs ack in one cycle
    b_mask = 8'hFF; b_type = 2'd1; b_src = 3'd7; b_id = 5'd20; b_empty = 1'b0;
    step();
    check("b.snoop.cmd", 32'(b_cmd), 32'h049249);
    check("b.snoop.busy", 32'(b_busy), 32'h1);
    b_ack = 8'h7F;
    step();
    check("b.enable.cmd", 32'(b_cmd), 32'h600000);
    check("b.enable.rd", 32'(b_rd), 32'h0);
    b_ack = 8'h80;
    step();
    check("b.pop.cmd", 32'(b_cmd), 32'h0);
    check("b.pop.rd", 32'(b_rd), 32'h1);
    b_ack = 8'h00; b_empty = 1'b1;
    step();
    check("b.idle.busy", 32'(b_busy), 32'h0);
    check("b.idle.err", 32'(b_err), 32'h0);

    // Reset pulse mid-SNOOP: entry is not popped and restarts afterwards
    a_mask = 4'hF; a_type = 2'd1; a_src = 2'd1; a_id = 5'd6; a_empty = 1'b0;
    step(); expect_a("rst.snoop", 12'h241, 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    expect_a("rst.async", 12'h000, 1'b0, 1'b0);
    expect_err_a("rst.async", 1'b0, 5'd0);
    step(); expect_a("rst.held", 12'h000, 1'b0, 1'b0);
    rst = 1'b1;
    step(); expect_a("rst.restart", 12'h241, 1'b0, 1'b1);
    a_ack = 4'b1101;
    step(); expect_a("rst.enable", 12'h018, 1'b0, 1'b1);
    a_ack = 4'b0010;
    step(); expect_a("rst.pop", 12'h000, 1'b1, 1'b1);
    a_ack = 4'b0000; a_empty = 1'b1;
    step(); expect_a("rst.idle", 12'h000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
